pipeline_ram: RTL and testbench

//  - Unified 256 x 16-bit memory for the 16-bit pipelined processor.
//  - Serves instruction fetch (addressed by pc) and load/store (base register + 6-bit signed offset).
//  - Sits between the EX stage (address/data) and MEM/WB (data_out); it is the single memory in the core.
//  - Single clock; synchronous write; registered (1-cycle) read.

---
 rtl/pipeline_ram.sv | 105 ++++++++++
 tb/tb_pipeline_ram.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pipeline_ram.sv
// -----------------------------------------------------------------------------
// pipeline_ram
//   Unified 256 x 16-bit memory shared by instruction fetch and load/store in
//   the 16-bit pipelined core. Writes are synchronous and reads are registered,
//   so read data appears one clock after the request.
//
//   Addressing:
//     - Load/store effective address ea = (rs_data + sign_extend(constant))
//       truncated to ADDR_W bits. This wraps modulo 2**ADDR_W.
//     - Instruction fetch uses pc directly.
//
//   Reset (synchronous, active-low): clears data_out and every memory word.
//   Any read or write request in the reset cycle is dropped.
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       synchronous active-low reset
//   pc         in   ADDR_W  instruction-fetch address
//   mem_read   in   1       1 = load from ea, 0 = fetch from pc
//   mem_write  in   1       1 = store data_in at ea
//   constant   in   OFF_W   signed address offset
//   rs_data    in   DATA_W  base register value
//   data_in    in   DATA_W  store data
//   data_out   out  DATA_W  registered read data
// -----------------------------------------------------------------------------
module pipeline_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int OFF_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [OFF_W-1:0]  constant,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  // ---------------------------------------------------------------------------
  // Effective address: full-width add of the sign-extended offset, then keep
  // only the low address bits so high base-register bits have no effect.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] offset_ext;
  logic [DATA_W-1:0] ea_sum;
  logic [ADDR_W-1:0] ea;

  assign offset_ext = {{(DATA_W - OFF_W){constant[OFF_W-1]}}, constant};
  assign ea_sum     = rs_data + offset_ext;
  assign ea         = ea_sum[ADDR_W-1:0];

  // Loads take priority over fetch for the single read port.
  logic [ADDR_W-1:0] rd_addr;
  assign rd_addr = mem_read ? ea : pc;

  // ---------------------------------------------------------------------------
  // Per-word write enables. Decoding one-hot here keeps the storage loop a
  // plain enable-per-word structure, which is also what the whole-array clear
  // requires (the array cannot map to a RAM macro with a one-cycle clear).
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] wr_sel;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = mem_write && (ea == ADDR_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Storage. Reset has priority, so a store coinciding with reset never lands.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n) begin
        mem_reg[i] <= '0;
      end else if (wr_sel[i]) begin
        mem_reg[i] <= data_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read. The array is sampled before this edge's write takes
  // effect, so a read of the address being written returns the old word.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] data_out_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_reg <= '0;
    end else begin
      data_out_reg <= mem_reg[rd_addr];
    end
  end

  assign data_out = data_out_reg;

endmodule

// File: tb/tb_pipeline_ram.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ram
//   Directed test of pipeline_ram: reset clear, store/load with positive and
//   negative offsets, address wrap, fetch vs. load select, read-before-write
//   and reset aborting a store.
// -----------------------------------------------------------------------------
module tb_pipeline_ram;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pc;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  constant;
  logic [15:0] rs_data;
  logic [15:0] data_in;
  logic [15:0] data_out;

  int total_cnt;
  int bad_cnt;

  pipeline_ram dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .constant  (constant),
    .rs_data   (rs_data),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%04h exp=0x%04h", tag, got, exp);
    end else begin
      $display("ok   %s: data_out=0x%04h", tag, got);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst_n     = 1'b0;
    pc        = 8'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    constant  = 6'd0;
    rs_data   = 16'd0;
    data_in   = 16'd0;

    // Reset held for two clocks
    step();
    check("reset_cyc1", data_out, 16'h0000);
    step();
    check("reset_cyc2", data_out, 16'h0000);
    rst_n = 1'b1;

    // All words read zero after reset
    for (int i = 0; i < 256; i++) begin
      pc = 8'(i);
      step();
      check($sformatf("fetch_zero_%0d", i), data_out, 16'h0000);
    end

    // Store 0x00A5 at 2 + 1 = 3, then load it back
    rs_data = 16'd2; constant = 6'd1; data_in = 16'h00A5; mem_write = 1'b1;
    step();
    mem_write = 1'b0; mem_read = 1'b1;
    step();
    check("load_pos_off", data_out, 16'h00A5);

    // Store 0x1234 at 1 + (-2) = 255 (wrap)
    rs_data = 16'h0001; constant = 6'b111110; data_in = 16'h1234;
    mem_read = 1'b0; mem_write = 1'b1;
    step();
    mem_write = 1'b0; pc = 8'd255;
    step();
    check("fetch_wrap_255", data_out, 16'h1234);
    mem_read = 1'b1;
    step();
    check("load_neg_off", data_out, 16'h1234);

    // High base bits ignored: 0x0103 -> word 3
    rs_data = 16'h0103; constant = 6'd0;
    step();
    check("load_high_bits", data_out, 16'h00A5);

    // Fetch vs. load select
    mem_read = 1'b0; mem_write = 1'b1; constant = 6'd0;
    rs_data = 16'd1; data_in = 16'h1111;
    step();
    rs_data = 16'd3; data_in = 16'h3333;
    step();
    mem_write = 1'b0; pc = 8'd1;
    step();
    check("fetch_pc1", data_out, 16'h1111);
    mem_read = 1'b1; rs_data = 16'd3;
    step();
    check("load_over_fetch", data_out, 16'h3333);

    // Simultaneous read and write of ea 3 returns old word
    mem_write = 1'b1; data_in = 16'hBEEF;
    step();
    check("rbw_old", data_out, 16'h3333);
    mem_write = 1'b0;
    step();
    check("rbw_new", data_out, 16'hBEEF);

    // Fetch in the same cycle as a store to that pc
    mem_read = 1'b0; pc = 8'd5; rs_data = 16'd5; data_in = 16'h5555; mem_write = 1'b1;
    step();
    check("fetch_store_old", data_out, 16'h0000);
    mem_write = 1'b0;
    step();
    check("fetch_store_new", data_out, 16'h5555);

    // Preload word 7, then reset in the same cycle as a store of 0xFFFF there
    rs_data = 16'd7; data_in = 16'h7777; mem_write = 1'b1;
    step();
    data_in = 16'hFFFF; rst_n = 1'b0; mem_read = 1'b1;
    step();
    check("reset_mid_out", data_out, 16'h0000);
    rst_n = 1'b1; mem_write = 1'b0; mem_read = 1'b0; pc = 8'd7;
    step();
    check("reset_mid_mem7", data_out, 16'h0000);
    pc = 8'd3;
    step();
    check("reset_clears_mem3", data_out, 16'h0000);
    pc = 8'd255;
    step();
    check("reset_clears_mem255", data_out, 16'h0000);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
